// File: rtl/pipe_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor: each stage ripples one SEG-bit slice
// through FullAdder cells and hands its carry, skewed operands and partial sum on.

module FullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module pipe_rca_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             c0,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  logic             w_adv;
  logic             w_cin;
  logic [WIDTH-1:0] w_bop;
  logic             r_ovf;

  assign w_bop    = B ^ {WIDTH{sub}};
  assign w_cin    = sub | c0;
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  genvar k, j;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG;

    logic [SEG-1:0] w_aSeg;
    logic [SEG-1:0] w_bSeg;
    logic [SEG-1:0] w_sum;
    logic [SEG:0]   w_chain;
    logic           w_vIn;
    logic [HI-1:0]  w_sNext;
    logic           r_v;
    logic           r_c;
    logic [HI-1:0]  r_s;

    if (k == 0) begin : g_head
      assign w_aSeg     = A[SEG-1:0];
      assign w_bSeg     = w_bop[SEG-1:0];
      assign w_chain[0] = w_cin;
      assign w_vIn      = in_valid;
      assign w_sNext    = w_sum;
    end else begin : g_body
      assign w_aSeg     = g_stage[k-1].g_skew.r_a[HI-1:LO];
      assign w_bSeg     = g_stage[k-1].g_skew.r_b[HI-1:LO];
      assign w_chain[0] = g_stage[k-1].r_c;
      assign w_vIn      = g_stage[k-1].r_v;
      assign w_sNext    = {w_sum, g_stage[k-1].r_s};
    end

    for (j = 0; j < SEG; j++) begin : g_bit
      FullAdder u_fa (
        .i_a (w_aSeg[j]),
        .i_b (w_bSeg[j]),
        .i_c (w_chain[j]),
        .o_s (w_sum[j]),
        .o_c (w_chain[j+1])
      );
    end

    // The completed low slices grow by SEG bits per stage so all bits leave together.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_vIn;
        r_c <= w_chain[SEG];
        r_s <= w_sNext;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:HI] w_aFwd;
      logic [WIDTH-1:HI] w_bFwd;
      logic [WIDTH-1:HI] r_a;
      logic [WIDTH-1:HI] r_b;

      if (k == 0) begin : g_src
        assign w_aFwd = A[WIDTH-1:HI];
        assign w_bFwd = w_bop[WIDTH-1:HI];
      end else begin : g_src
        assign w_aFwd = g_stage[k-1].g_skew.r_a[WIDTH-1:HI];
        assign w_bFwd = g_stage[k-1].g_skew.r_b[WIDTH-1:HI];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_aFwd;
          r_b <= w_bFwd;
        end
      end
    end
  end

  // Overflow compares the carry into and out of the MSB cell of the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= g_stage[STAGES-1].w_chain[SEG] ^ g_stage[STAGES-1].w_chain[SEG-1];
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign S         = g_stage[STAGES-1].r_s;
  assign cout      = g_stage[STAGES-1].r_c;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_rca_addsub.sv
// Directed bench driving three pipe_rca_addsub builds (STAGES 4, 1, 16) with
// hand-computed vectors; a monitor pops expected results as each one retires.

module tb_pipe_rca_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  inValid;
  logic [2:0]  outReady;
  logic        sub;
  logic        c0;
  logic [15:0] a;
  logic [15:0] b;

  logic        irOut   [3];
  logic        ovOut   [3];
  logic        coutOut [3];
  logic        ovfOut  [3];
  logic [15:0] sOut    [3];

  logic [17:0] expQ [3][$];
  logic [17:0] monExp;
  int          assertCount = 0;
  int          failCount   = 0;
  int          lat [3];
  logic [31:0] pat [3];

  always #5 clk = ~clk;

  pipe_rca_addsub #(.WIDTH(16), .STAGES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(irOut[0]),
    .sub(sub), .c0(c0), .A(a), .B(b),
    .out_valid(ovOut[0]), .out_ready(outReady[0]),
    .S(sOut[0]), .cout(coutOut[0]), .ovf(ovfOut[0])
  );

  pipe_rca_addsub #(.WIDTH(16), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(irOut[1]),
    .sub(sub), .c0(c0), .A(a), .B(b),
    .out_valid(ovOut[1]), .out_ready(outReady[1]),
    .S(sOut[1]), .cout(coutOut[1]), .ovf(ovfOut[1])
  );

  pipe_rca_addsub #(.WIDTH(16), .STAGES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(irOut[2]),
    .sub(sub), .c0(c0), .A(a), .B(b),
    .out_valid(ovOut[2]), .out_ready(outReady[2]),
    .S(sOut[2]), .cout(coutOut[2]), .ovf(ovfOut[2])
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Presents one operation to the DUTs in mask; expected word is {cout, ovf, S}.
  task automatic applyStimulus(input logic [2:0] mask, input logic subV, input logic c0V,
                               input logic [15:0] aV, input logic [15:0] bV,
                               input logic [17:0] expV);
    @(negedge clk);
    sub     = subV;
    c0      = c0V;
    a       = aV;
    b       = bV;
    inValid = mask;
    #1;
    for (int d = 0; d < 3; d++)
      if (mask[d] && irOut[d]) expQ[d].push_back(expV);
    @(posedge clk);
    #1 inValid = 3'b000;
  endtask

  task automatic recordPatterns();
    for (int d = 0; d < 3; d++) pat[d] = '0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 3; d++) pat[d][i] = ovOut[d];
    end
  endtask

  // Scoreboard: each retiring result must match the oldest accepted operation.
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (ovOut[d] && outReady[d]) begin
          if (expQ[d].size() == 0) begin
            checkOutput($sformatf("stale[%0d]", d), 32'd1, 32'd0);
          end else begin
            monExp = expQ[d].pop_front();
            checkOutput($sformatf("result[%0d]", d),
                        {14'b0, coutOut[d], ovfOut[d], sOut[d]}, {14'b0, monExp});
          end
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    inValid  = 3'b000;
    outReady = 3'b111;
    sub      = 1'b0;
    c0       = 1'b0;
    a        = '0;
    b        = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("resetOut[%0d]", d),
                  {13'b0, ovOut[d], coutOut[d], ovfOut[d], sOut[d]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #2;
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("readyAfterReset[%0d]", d), {31'b0, irOut[d]}, 32'd1);

    $display("[TB] directed vectors and latency");
    applyStimulus(3'b111, 1'b0, 1'b0, 16'hFFFF, 16'h0001, {1'b1, 1'b0, 16'h0000});
    for (int d = 0; d < 3; d++) lat[d] = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      #2;
      for (int d = 0; d < 3; d++)
        if (ovOut[d] && lat[d] == 0) lat[d] = n;
      @(posedge clk);
    end
    checkOutput("latency4",  lat[0], 32'd4);
    checkOutput("latency1",  lat[1], 32'd1);
    checkOutput("latency16", lat[2], 32'd16);

    applyStimulus(3'b111, 1'b1, 1'b0, 16'h8000, 16'h0001, {1'b1, 1'b1, 16'h7FFF});
    applyStimulus(3'b111, 1'b1, 1'b0, 16'h0003, 16'h0005, {1'b0, 1'b0, 16'hFFFE});
    applyStimulus(3'b111, 1'b0, 1'b1, 16'h0FFF, 16'h0000, {1'b0, 1'b0, 16'h1000});
    applyStimulus(3'b111, 1'b1, 1'b1, 16'h0FFF, 16'h0000, {1'b1, 1'b0, 16'h0FFF});
    applyStimulus(3'b111, 1'b0, 1'b0, 16'h7FFF, 16'h0001, {1'b0, 1'b1, 16'h8000});
    applyStimulus(3'b111, 1'b0, 1'b1, 16'h1234, 16'h4321, {1'b0, 1'b0, 16'h5556});
    repeat (24) @(posedge clk);

    $display("[TB] back-to-back throughput");
    fork
      begin
        for (int i = 1; i <= 8; i++)
          applyStimulus(3'b111, 1'b0, 1'b0, 16'(i), 16'(16'h1111 * i),
                        {2'b00, 16'(16'h1112 * i)});
      end
      recordPatterns();
    join
    checkOutput("throughputPat4",  pat[0], 32'h0000_0FF0);
    checkOutput("throughputPat1",  pat[1], 32'h0000_01FE);
    checkOutput("throughputPat16", pat[2], 32'h00FF_0000);
    repeat (8) @(posedge clk);

    $display("[TB] backpressure on the STAGES=4 build");
    for (int i = 1; i <= 4; i++)
      applyStimulus(3'b001, 1'b0, 1'b0, 16'(16'h0101 * i), 16'h0010,
                    {2'b00, 16'(16'h0101 * i + 16'h0010)});
    @(negedge clk);
    outReady = 3'b110;
    inValid  = 3'b001;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    for (int c = 0; c < 3; c++) begin
      #2;
      checkOutput($sformatf("stallReady%0d", c), {31'b0, irOut[0]}, 32'd0);
      checkOutput($sformatf("stallHold%0d", c),
                  {13'b0, ovOut[0], coutOut[0], ovfOut[0], sOut[0]},
                  {13'b0, 1'b1, 1'b0, 1'b0, 16'h0111});
      @(negedge clk);
    end
    inValid  = 3'b000;
    outReady = 3'b111;
    applyStimulus(3'b001, 1'b0, 1'b0, 16'h0505, 16'h0010, {2'b00, 16'h0515});
    applyStimulus(3'b001, 1'b0, 1'b0, 16'h0606, 16'h0010, {2'b00, 16'h0616});
    repeat (12) @(posedge clk);
    checkOutput("drainAfterStall", expQ[0].size(), 32'd0);

    $display("[TB] reset with operations in flight");
    applyStimulus(3'b111, 1'b0, 1'b0, 16'h1111, 16'h2222, {2'b00, 16'h3333});
    applyStimulus(3'b111, 1'b0, 1'b0, 16'h4444, 16'h1111, {2'b00, 16'h5555});
    applyStimulus(3'b111, 1'b1, 1'b0, 16'h9999, 16'h1111, {1'b1, 1'b0, 16'h8888});
    @(negedge clk);
    rst     = 1'b1;
    inValid = 3'b111;
    a       = 16'hAAAA;
    b       = 16'h5555;
    #1;
    for (int d = 0; d < 3; d++) expQ[d].delete();
    @(posedge clk);
    #1 inValid = 3'b000;
    @(negedge clk);
    #2;
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("flushOut[%0d]", d), {15'b0, ovOut[d], sOut[d]}, 32'd0);
    rst = 1'b0;

    $display("[TB] operations every other cycle");
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          applyStimulus(3'b111, 1'b0, 1'b0, 16'(16'h1000 * k), 16'h0001,
                        {2'b00, 16'(16'h1000 * k + 1)});
          @(negedge clk);
        end
      end
      recordPatterns();
    join
    checkOutput("bubblePat4",  pat[0], 32'h0000_0550);
    checkOutput("bubblePat1",  pat[1], 32'h0000_00AA);
    checkOutput("bubblePat16", pat[2], 32'h0055_0000);

    repeat (40) @(posedge clk);
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("finalDrain[%0d]", d), expQ[d].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
